// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB sequencing controller.
package tlb_pkg;

  localparam int VPN_W       = 20;
  localparam int PPN_W       = 22;
  localparam int IDX_W       = 6;
  localparam int TAG_W       = VPN_W - IDX_W;
  localparam int PERM_W      = 4;
  localparam int ENTRY_W     = 64;
  localparam int TLB_ENTRIES = 64;

  // Entry layout inside one 64-bit SRAM word; bits below PERM_LO are written as 0.
  localparam int V_BIT   = 63;
  localparam int TAG_HI  = 62;
  localparam int TAG_LO  = 49;
  localparam int PPN_HI  = 48;
  localparam int PPN_LO  = 27;
  localparam int PERM_HI = 26;
  localparam int PERM_LO = 23;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } tlb_state_e;

  typedef struct packed {
    logic              v;
    logic [TAG_W-1:0]  tag;
    logic [PPN_W-1:0]  ppn;
    logic [PERM_W-1:0] perm;
  } tlb_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input tlb_entry_t e);
    logic [ENTRY_W-1:0] w;
    w                  = '0;
    w[V_BIT]           = e.v;
    w[TAG_HI:TAG_LO]   = e.tag;
    w[PPN_HI:PPN_LO]   = e.ppn;
    w[PERM_HI:PERM_LO] = e.perm;
    return w;
  endfunction

  function automatic tlb_entry_t unpack_entry(input logic [ENTRY_W-1:0] w);
    tlb_entry_t e;
    logic       unused_pad;
    unused_pad = ^w[PERM_LO-1:0];
    e.v        = w[V_BIT];
    e.tag      = w[TAG_HI:TAG_LO];
    e.ppn      = w[PPN_HI:PPN_LO];
    e.perm     = w[PERM_HI:PERM_LO];
    return e;
  endfunction

endpackage

// File: rtl/tlb_lookup_pipe.sv
// Port 1 lookup path: registers the SRAM read, carries valid/tag alongside
// the SRAM latency and compares against the returned word.
module tlb_lookup_pipe
  import tlb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_fire,
  input  logic [VPN_W-1:0]   req_vpn,
  output logic               sram_csb1,
  output logic [IDX_W-1:0]   sram_addr1,
  input  logic [ENTRY_W-1:0] sram_dout1,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [PPN_W-1:0]   rsp_ppn,
  output logic [PERM_W-1:0]  rsp_perm
);

  logic              csb1_q, csb1_d;
  logic [IDX_W-1:0]  addr1_q, addr1_d;
  logic              s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [TAG_W-1:0]  s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [PPN_W-1:0]  rsp_ppn_q, rsp_ppn_d;
  logic [PERM_W-1:0] rsp_perm_q, rsp_perm_d;
  tlb_entry_t        rd_entry;

  // Next-state: issue read, shift valid/tag, compare at the third stage.
  always_comb begin
    rd_entry    = unpack_entry(sram_dout1);
    csb1_d      = ~req_fire;
    addr1_d     = req_fire ? req_vpn[IDX_W-1:0] : addr1_q;
    s0_vld_d    = req_fire;
    s0_tag_d    = req_vpn[VPN_W-1:IDX_W];
    s1_vld_d    = s0_vld_q;
    s1_tag_d    = s0_tag_q;
    s2_vld_d    = s1_vld_q;
    s2_tag_d    = s1_tag_q;
    rsp_valid_d = s2_vld_q;
    rsp_hit_d   = s2_vld_q && rd_entry.v && (rd_entry.tag == s2_tag_q);
    rsp_ppn_d   = rsp_hit_d ? rd_entry.ppn  : '0;
    rsp_perm_d  = rsp_hit_d ? rd_entry.perm : '0;
  end

  // Pipeline registers; reset drops every in-flight lookup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csb1_q      <= 1'b1;
      addr1_q     <= '0;
      s0_vld_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s0_tag_q    <= '0;
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_ppn_q   <= '0;
      rsp_perm_q  <= '0;
    end else begin
      csb1_q      <= csb1_d;
      addr1_q     <= addr1_d;
      s0_vld_q    <= s0_vld_d;
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      s0_tag_q    <= s0_tag_d;
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_ppn_q   <= rsp_ppn_d;
      rsp_perm_q  <= rsp_perm_d;
    end
  end

  assign sram_csb1  = csb1_q;
  assign sram_addr1 = addr1_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_ppn    = rsp_ppn_q;
  assign rsp_perm   = rsp_perm_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB SRAM sequencing controller: invalidate sweep after reset and on
// request, single-entry fills on port 0, pipelined lookups on port 1.
//
// Handshake: lk_* and fill_* transfer on a clock edge where valid && ready;
// ready depends only on controller state and flush_req, never on valid.
// rsp_valid is a one-cycle pulse with no backpressure.
module tlb_ctrl
  import tlb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [VPN_W-1:0]   lk_vpn,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [PPN_W-1:0]   rsp_ppn,
  output logic [PERM_W-1:0]  rsp_perm,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [VPN_W-1:0]   fill_vpn,
  input  logic [PPN_W-1:0]   fill_ppn,
  input  logic [PERM_W-1:0]  fill_perm,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [IDX_W-1:0]   sram_addr0,
  output logic [ENTRY_W-1:0] sram_din0,
  output logic               sram_csb1,
  output logic [IDX_W-1:0]   sram_addr1,
  input  logic [ENTRY_W-1:0] sram_dout1,
  output logic [1:0]         dbg_state
);

  tlb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               csb0_q, csb0_d;
  logic               web0_q, web0_d;
  logic [IDX_W-1:0]   addr0_q, addr0_d;
  logic [ENTRY_W-1:0] din0_q, din0_d;
  logic               accept_ok;
  logic               fill_fire;
  logic               lk_fire;
  tlb_entry_t         fill_entry;

  // flush_req blocks new work in the same cycle it is seen.
  assign accept_ok  = (state_q == ST_IDLE) && !flush_req;
  assign lk_ready   = accept_ok;
  assign fill_ready = accept_ok;
  assign fill_fire  = fill_valid && accept_ok;
  assign lk_fire    = lk_valid && accept_ok;
  assign flush_busy = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  // FSM next state, sweep counter and port 0 request mux.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    csb0_d          = 1'b1;
    web0_d          = 1'b1;
    addr0_d         = addr0_q;
    din0_d          = din0_q;
    fill_entry.v    = 1'b1;
    fill_entry.tag  = fill_vpn[VPN_W-1:IDX_W];
    fill_entry.ppn  = fill_ppn;
    fill_entry.perm = fill_perm;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        csb0_d  = 1'b0;
        web0_d  = 1'b0;
        addr0_d = cnt_q;
        din0_d  = '0;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(TLB_ENTRIES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (fill_fire) begin
          csb0_d  = 1'b0;
          web0_d  = 1'b0;
          addr0_d = fill_vpn[IDX_W-1:0];
          din0_d  = pack_entry(fill_entry);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered port 0 outputs; reset restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csb0_q  <= csb0_d;
      web0_q  <= web0_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
    end
  end

  assign sram_csb0  = csb0_q;
  assign sram_web0  = web0_q;
  assign sram_addr0 = addr0_q;
  assign sram_din0  = din0_q;

  tlb_lookup_pipe u_lookup (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_fire   (lk_fire),
    .req_vpn    (lk_vpn),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_ppn    (rsp_ppn),
    .rsp_perm   (rsp_perm)
  );

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl with a behavioural dual-port SRAM model.
module tb_tlb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic        lk_ready;
  logic [19:0] lk_vpn;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [21:0] rsp_ppn;
  logic [3:0]  rsp_perm;
  logic        fill_valid;
  logic        fill_ready;
  logic [19:0] fill_vpn;
  logic [21:0] fill_ppn;
  logic [3:0]  fill_perm;
  logic        flush_req;
  logic        flush_busy;
  logic        sram_csb0;
  logic        sram_web0;
  logic [5:0]  sram_addr0;
  logic [63:0] sram_din0;
  logic        sram_csb1;
  logic [5:0]  sram_addr1;
  logic [63:0] sram_dout1 = '0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_cnt  = 0;

  logic [26:0] exp_q[$];
  int          lat_q[$];

  tlb_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_vpn     (lk_vpn),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_ppn    (rsp_ppn),
    .rsp_perm   (rsp_perm),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_vpn   (fill_vpn),
    .fill_ppn   (fill_ppn),
    .fill_perm  (fill_perm),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model ----------------
  // Requests captured at posedge; write lands on the following negedge;
  // read data appears at the next posedge and holds for a cycle.
  logic [63:0] mem [64];
  logic        p0_we   = 1'b0;
  logic [5:0]  p0_addr = '0;
  logic [63:0] p0_din  = '0;
  logic        p1_re   = 1'b0;
  logic [5:0]  p1_addr = '0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {1'b1, 31'($urandom), 32'($urandom)};
  end

  always @(posedge clk) begin
    if (p1_re) sram_dout1 <= mem[p1_addr];
    p0_we   <= !sram_csb0 && !sram_web0;
    p0_addr <= sram_addr0;
    p0_din  <= sram_din0;
    p1_re   <= !sram_csb1;
    p1_addr <= sram_addr1;
  end

  always @(negedge clk) begin
    if (p0_we) mem[p0_addr] = p0_din;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [26:0] e;
    int          l;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("rsp_latency", 64'(cyc), 64'(l + 3));
        chk("rsp_hit", rsp_hit, e[26]);
        chk("rsp_ppn", rsp_ppn, e[25:4]);
        chk("rsp_perm", rsp_perm, e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (lk_ready !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (lk_ready !== 1'b1) chk("ready_timeout", lk_ready, 1);
  endtask

  task automatic lookup(input logic [19:0] vpn, input logic hit, input logic [21:0] ppn,
                        input logic [3:0] perm, input bit expect_rsp);
    wait_ready();
    lk_valid = 1'b1;
    lk_vpn   = vpn;
    @(posedge clk);
    #1;
    if (expect_rsp) begin
      exp_q.push_back({hit, ppn, perm});
      lat_q.push_back(cyc);
    end
    lk_valid = 1'b0;
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [21:0] ppn, input logic [3:0] perm);
    wait_ready();
    fill_valid = 1'b1;
    fill_vpn   = vpn;
    fill_ppn   = ppn;
    fill_perm  = perm;
    @(posedge clk);
    #1;
    fill_valid = 1'b0;
  endtask

  task automatic fill_lookup(input logic [19:0] vpn, input logic [21:0] ppn, input logic [3:0] perm);
    wait_ready();
    fill_valid = 1'b1;
    fill_vpn   = vpn;
    fill_ppn   = ppn;
    fill_perm  = perm;
    lk_valid   = 1'b1;
    lk_vpn     = vpn;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, ppn, perm});
    lat_q.push_back(cyc);
    fill_valid = 1'b0;
    lk_valid   = 1'b0;
  endtask

  // Called right after the edge that starts the sweep state; checks the
  // idle cycle before the first write and all 64 zeroing writes.
  task automatic check_sweep(input string tag);
    @(negedge clk);
    chk({tag, "_pre_busy"}, flush_busy, 1);
    chk({tag, "_pre_csb0"}, sram_csb0, 1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk({tag, "_csb0"}, sram_csb0, 0);
      chk({tag, "_web0"}, sram_web0, 0);
      chk({tag, "_addr0"}, sram_addr0, 64'(i));
      chk({tag, "_din0"}, sram_din0, 0);
      chk({tag, "_busy"}, flush_busy, (i < 63) ? 1 : 0);
      chk({tag, "_ready"}, lk_ready, (i == 63) ? 1 : 0);
    end
    @(negedge clk);
    chk({tag, "_post_csb0"}, sram_csb0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int saved;
    rst_n      = 1'b0;
    lk_valid   = 1'b0;
    lk_vpn     = '0;
    fill_valid = 1'b0;
    fill_vpn   = '0;
    fill_ppn   = '0;
    fill_perm  = '0;
    flush_req  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_web0", sram_web0, 1);
    chk("rst_csb1", sram_csb1, 1);
    chk("rst_addr0", sram_addr0, 0);
    chk("rst_addr1", sram_addr1, 0);
    chk("rst_din0", sram_din0, 0);
    chk("rst_rsp", {rsp_valid, rsp_hit, rsp_ppn, rsp_perm}, 0);
    chk("rst_busy", flush_busy, 1);
    chk("rst_state", dbg_state, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep("init");

    // Empty array after the sweep
    lookup(20'h00000, 0, 22'h0, 4'h0, 1);

    // Fill then hit; same index with different tag misses
    fill(20'h12345, 22'h3ABCDE, 4'hB);
    lookup(20'h12345, 1, 22'h3ABCDE, 4'hB, 1);
    lookup(20'h52345, 0, 22'h0, 4'h0, 1);

    // Lookup one cycle before the fill misses; same-cycle lookup hits
    lookup(20'h00A07, 0, 22'h0, 4'h0, 1);
    fill_lookup(20'h00A07, 22'h155555, 4'h5);

    // Back-to-back fills, then back-to-back lookups
    fill(20'h00001, 22'h000111, 4'h1);
    fill(20'h00042, 22'h2FFFFF, 4'hF);
    fill(20'hFFFFF, 22'h3FFFFF, 4'hF);
    lookup(20'h12345, 1, 22'h3ABCDE, 4'hB, 1);
    lookup(20'h00001, 1, 22'h000111, 4'h1, 1);
    lookup(20'h00042, 1, 22'h2FFFFF, 4'hF, 1);
    lookup(20'h00003, 0, 22'h0, 4'h0, 1);
    lookup(20'hFFFFF, 1, 22'h3FFFFF, 4'hF, 1);

    // Overwrite index 5 with another tag, then restore it
    fill(20'h52345, 22'h000ABC, 4'h3);
    lookup(20'h52345, 1, 22'h000ABC, 4'h3, 1);
    lookup(20'h12345, 0, 22'h0, 4'h0, 1);
    fill(20'h12345, 22'h3ABCDE, 4'hB);
    repeat (2) @(posedge clk);
    #1;

    // Lookup in flight when flush starts still hits with old contents
    lookup(20'h12345, 1, 22'h3ABCDE, 4'hB, 1);
    flush_req = 1'b1;
    #1;
    chk("flush_tie_lk_ready", lk_ready, 0);
    chk("flush_tie_fill_ready", fill_ready, 0);
    @(posedge clk);
    #1 flush_req = 1'b0;
    fork
      check_sweep("flush");
      begin
        repeat (20) @(posedge clk);
        #1 flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
      end
    join
    lookup(20'h12345, 0, 22'h0, 4'h0, 1);
    lookup(20'hFFFFF, 0, 22'h0, 4'h0, 1);
    repeat (6) @(posedge clk);
    #1;

    // Reset with a lookup in the pipe: no response, sweep restarts at 0
    fill(20'h00042, 22'h2FFFFF, 4'hF);
    lookup(20'h00042, 1, 22'h0, 4'h0, 0);
    saved = rsp_cnt;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep("rst2");
    chk("no_rsp_after_reset", 64'(rsp_cnt), 64'(saved));
    lookup(20'h00042, 0, 22'h0, 4'h0, 1);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
Sequencing controller for the 64-entry x 64-bit dual-port TLB SRAM macro (port 0 read/write, port 1 read-only, active-low chip/write selects). It owns both SRAM ports and provides three services: a pipelined lookup path on port 1, single-entry fills on port 0, and a full-array invalidate sweep on port 0. The SRAM has no reset, so the controller runs an automatic sweep after every reset. It sits between the MMU/page-walker and the TLB macro, direct-mapped on VPN[5:0].

Parameters:
VPN_W, 20, virtual page number width (32-bit VA, 4 KiB pages)
PPN_W, 22, physical page number width
IDX_W, 6, SRAM index width; fixed by the macro
TAG_W, VPN_W-IDX_W (14), stored tag width

Ports:
clk  in  1  single clock; the SRAM clk0 and clk1 are tied to it externally
rst_n  in  1  synchronous active-low reset
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted when lk_valid && lk_ready
lk_vpn  in  VPN_W  lookup VPN
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_hit  out  1  entry valid and tag match
rsp_ppn  out  PPN_W  translated PPN; 0 on miss
rsp_perm  out  4  {U,X,W,R}; 0 on miss
fill_valid  in  1  write request
fill_ready  out  1  fill accepted when fill_valid && fill_ready
fill_vpn  in  VPN_W  VPN to install
fill_ppn  in  PPN_W  PPN to install
fill_perm  in  4  {U,X,W,R}
flush_req  in  1  invalidate-all request, sampled in IDLE
flush_busy  out  1  high while the sweep is running (INIT or FLUSH)
sram_csb0  out  1  port 0 chip select, active low
sram_web0  out  1  port 0 write enable, active low
sram_addr0  out  IDX_W  port 0 address
sram_din0  out  64  port 0 write data
sram_csb1  out  1  port 1 chip select, active low
sram_addr1  out  IDX_W  port 1 address
sram_dout1  in  64  port 1 read data

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- All sram_* outputs are registered.
- Reset values: sram_csb0=1, sram_web0=1, sram_csb1=1, sram_addr0=0, sram_addr1=0, sram_din0=0, rsp_valid=0, rsp_hit=0, rsp_ppn=0, rsp_perm=0, flush_busy=1. All pipeline valid bits are cleared.
- Entry format:
  - [63] V
  - [62:49] TAG (VPN[19:6])
  - [48:27] PPN
  - [26:23] {U,X,W,R}
  - [22:0] written as 0
- FSM states: INIT, IDLE, FLUSH. The reset state is INIT.
  - INIT/FLUSH: sweep counter cnt runs 0..63. Each cycle registers csb0=0, web0=0, addr0=cnt, din0=0.
  - After the write with cnt=63, go to IDLE. The sweep takes exactly 64 cycles.
  - IDLE -> FLUSH when flush_req=1. cnt restarts from 0.
  - flush_req while already in FLUSH or INIT is ignored.
- Ready signals: lk_ready = fill_ready = (state==IDLE) && !flush_req. flush_req wins ties.
- Fill: on acceptance, the next edge registers a port 0 write (addr0=fill_vpn[5:0], din0=packed entry with V=1). Throughput is one fill per cycle. csb0/web0 return to 1 on cycles with no write.
- Lookup pipeline: accept at edge k.
  - Edge k: register csb1=0, addr1=idx. Carry valid and tag down the pipe.
  - Edge k+1: the SRAM captures the request.
  - Edge k+2: sram_dout1 is valid.
  - Edge k+3: compare and register the response. rsp_valid is high in the cycle after edge k+3.
  - Throughput: one lookup per cycle.
- Hit rule: hit = dout[63] && dout[62:49]==tag. On miss, rsp_ppn and rsp_perm are 0.
- Ordering: a fill accepted at edge F is visible to every lookup accepted at an edge >= F. This includes a lookup accepted in the same cycle as the fill. The SRAM's negedge write lands before the port 1 read. No stall is required.
- Flush vs. in-flight work: lookups already accepted complete and respond with pre-flush contents. They are not killed.
- Reset mid-operation: all in-flight lookups are dropped with no rsp_valid, and the sweep restarts at 0.
- Port 0 is never read; dout0 is left unconnected.

Decomposition:
- tlb_pkg holds:
  - entry field offsets and widths (V_BIT, TAG_HI/LO, PPN_HI/LO, PERM_HI/LO)
  - an entry struct with pack/unpack functions
  - the state enum {INIT, IDLE, FLUSH}
  - TLB_ENTRIES=64
- One sub-module, tlb_lookup_pipe: three-stage valid/tag pipeline plus compare. The FSM, sweep counter and port 0 mux stay in tlb_ctrl.

Test Plan:
- Reset release -> flush_busy=1 for 64 cycles with addr0 0..63, din0=0, web0=0; lk_ready=1 on cycle 65. Then a lookup of VPN 0x00000 -> rsp_hit=0, rsp_ppn=0.
- Fill VPN 0x12345, PPN 0x3ABCDE, perm 0xB; later look up 0x12345 -> 3 cycles after accept, rsp_valid=1, hit=1, ppn=0x3ABCDE, perm=0xB.
- Look up 0x52345 (same index 0x05, different tag) after that fill -> hit=0.
- Fill and lookup of VPN 0x00A07 accepted in the same cycle -> hit=1. A lookup accepted one cycle before the fill -> hit=0.
- Four back-to-back lookups -> four consecutive rsp_valid pulses, in order.
- Lookup in flight, then flush_req -> that lookup still hits. After flush_busy falls (64 cycles), the same VPN misses. Asserting rst_n=0 mid-pipe -> no rsp_valid.
